// File: rtl/regs_uart_fifo_if.sv
// rtl/regs_uart_fifo_if.sv - local-bus register port shared by CPU master and UART CSR slave
interface regs_uart_fifo_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic [STRB_W-1:0] wstrb;
  logic              wready;
  logic [ADDR_W-1:0] raddr;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output waddr, wdata, wen, wstrb, raddr, ren,
    input  wready, rdata, rvalid
  );

  modport slave (
    input  waddr, wdata, wen, wstrb, raddr, ren,
    output wready, rdata, rvalid
  );
endinterface

// File: rtl/regs_uart_fifo.sv
// rtl/regs_uart_fifo.sv - UART CSR block with TX/RX FIFOs, overflow flags and threshold irq
module regs_uart_fifo #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STRB_W     = DATA_W / 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regs_uart_fifo_if.slave      bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_STAT   = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_THRESH = ADDR_W'(32'h10);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [LVL_W-1:0] tx_level, rx_level;
  logic             tx_ovf, rx_ovf;
  logic [6:0]       ctrl;
  logic [7:0]       tx_thresh, rx_thresh;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic wr_txdata, wr_stat, wr_ctrl, wr_thresh, rd_rxdata;
  logic tx_push, tx_pop, tx_flush, tx_ovf_set;
  logic rx_push, rx_pop, rx_flush, rx_ovf_set;
  logic [31:0] stat_word, rd_word;
  logic irq_next;
  logic unused_bits;

  assign unused_bits = &{1'b0, bus.wdata[DATA_W-1:16], bus.wstrb[STRB_W-1:2]};
  assign bus.wready  = 1'b1;

  assign tx_full  = (tx_level == LVL_FULL);
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == LVL_FULL);
  assign rx_empty = (rx_level == '0);

  assign wr_txdata = bus.wen && (bus.waddr == A_TXDATA) && bus.wstrb[0];
  assign wr_stat   = bus.wen && (bus.waddr == A_STAT)   && bus.wstrb[0];
  assign wr_ctrl   = bus.wen && (bus.waddr == A_CTRL)   && bus.wstrb[0];
  assign wr_thresh = bus.wen && (bus.waddr == A_THRESH);
  assign rd_rxdata = bus.ren && (bus.raddr == A_RXDATA);

  assign tx_valid   = ctrl[0] && !tx_empty;
  assign tx_data    = tx_mem[tx_rd];
  assign tx_push    = wr_txdata && !tx_full;
  assign tx_ovf_set = wr_txdata && tx_full;
  assign tx_pop     = tx_valid && tx_ready;
  assign tx_flush   = wr_ctrl && bus.wdata[2];

  assign rx_push    = rx_valid && ctrl[1] && !rx_full;
  assign rx_ovf_set = rx_valid && ctrl[1] && rx_full;
  assign rx_pop     = rd_rxdata && !rx_empty;
  assign rx_flush   = wr_ctrl && bus.wdata[3];

  assign stat_word = {8'h00, 8'(rx_level), 8'(tx_level), 1'b0, tx_valid,
                      rx_ovf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rd_word = '0;
    case (bus.raddr)
      A_STAT:   rd_word = stat_word;
      A_CTRL:   rd_word = {25'b0, ctrl};
      A_RXDATA: rd_word = {!rx_empty, 23'b0, rx_empty ? 8'h00 : rx_mem[rx_rd]};
      A_THRESH: rd_word = {16'b0, rx_thresh, tx_thresh};
      default:  rd_word = '0;
    endcase
  end

  assign irq_next = (ctrl[4] && (8'(tx_level) <= tx_thresh))
                 || (ctrl[5] && (8'(rx_level) >= rx_thresh) && !rx_empty)
                 || (ctrl[6] && (tx_ovf || rx_ovf));

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.wdata[7:0];
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr <= '0; tx_rd <= '0; tx_level <= '0;
    end else if (tx_flush) begin
      tx_wr <= '0; tx_rd <= '0; tx_level <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PTR_W'(1);
      if (tx_pop)  tx_rd <= tx_rd + PTR_W'(1);
      tx_level <= tx_level + LVL_W'(tx_push) - LVL_W'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr <= '0; rx_rd <= '0; rx_level <= '0;
    end else if (rx_flush) begin
      rx_wr <= '0; rx_rd <= '0; rx_level <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PTR_W'(1);
      if (rx_pop)  rx_rd <= rx_rd + PTR_W'(1);
      rx_level <= rx_level + LVL_W'(rx_push) - LVL_W'(rx_pop);
    end
  end

  // Overflow set takes precedence over a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (tx_ovf_set)                     tx_ovf <= 1'b1;
      else if (wr_stat && bus.wdata[4])   tx_ovf <= 1'b0;
      if (rx_ovf_set)                     rx_ovf <= 1'b1;
      else if (wr_stat && bus.wdata[5])   rx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= 7'h03;
      tx_thresh <= 8'h00;
      rx_thresh <= 8'h01;
    end else begin
      if (wr_ctrl) ctrl <= bus.wdata[6:0] & 7'b1110011;
      if (wr_thresh && bus.wstrb[0]) tx_thresh <= bus.wdata[7:0];
      if (wr_thresh && bus.wstrb[1]) rx_thresh <= bus.wdata[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      irq        <= 1'b0;
    end else begin
      bus.rdata  <= bus.ren ? DATA_W'(rd_word) : '0;
      bus.rvalid <= bus.ren;
      irq        <= irq_next;
    end
  end
endmodule

// File: tb/tb_regs_uart_fifo.sv
// tb/tb_regs_uart_fifo.sv - directed self-checking bench for regs_uart_fifo
module tb_regs_uart_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       irq;
  int         checks = 0;
  int         errors = 0;

  regs_uart_fifo_if bus ();

  regs_uart_fifo dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.waddr = a; bus.wdata = d; bus.wstrb = s; bus.wen = 1'b1;
    tick();
    bus.wen = 1'b0; bus.wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    bus.raddr = a; bus.ren = 1'b1;
    tick();
    d = bus.rdata; v = bus.rvalid;
    bus.ren = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (tx_valid !== 1'b0 || irq !== 1'b0 || bus.rvalid !== 1'b0 || bus.wready !== 1'b1) begin
      errors++; $display("FAIL reset_outputs got txv=%b irq=%b rv=%b wr=%b want 0 0 0 1", tx_valid, irq, bus.rvalid, bus.wready); end
    bus_read(32'h04, d, v);
    checks++; if (d !== 32'h0000_000A || v !== 1'b1) begin
      errors++; $display("FAIL reset_stat got %h/%b want 0000000a/1", d, v); end
    tick();
    checks++; if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
      errors++; $display("FAIL rvalid_pulse got %b/%h want 0/0", bus.rvalid, bus.rdata); end
    bus_read(32'h08, d, v);
    checks++; if (d !== 32'h03) begin errors++; $display("FAIL reset_ctrl got %h want 03", d); end
    bus_read(32'h10, d, v);
    checks++; if (d !== 32'h0100) begin errors++; $display("FAIL reset_thresh got %h want 0100", d); end
    bus_read(32'h14, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL unmapped_read got %h/%b want 0/1", d, v); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d; logic v;
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) bus_write(32'h00, 32'h41 + i, 4'h1);
    bus_read(32'h04, d, v);
    checks++; if (d !== 32'h0000_1059) begin errors++; $display("FAIL tx_full_stat got %h want 00001059", d); end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        errors++; $display("FAIL tx_drain[%0d] got %b/%h want 1/%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained got txv=%b want 0", tx_valid); end
    tx_ready = 1'b0;
    bus_write(32'h04, 32'h10, 4'h1);
    bus_read(32'h04, d, v);
    checks++; if (d !== 32'h0000_000A) begin errors++; $display("FAIL tx_ovf_w1c got %h want 0000000a", d); end
  endtask

  task automatic test_rx_basic();
    logic [31:0] d; logic v;
    logic [31:0] exp [4];
    exp[0] = 32'h8000_0011; exp[1] = 32'h8000_0022; exp[2] = 32'h8000_0033; exp[3] = 32'h0;
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h0C, d, v);
      checks++; if (d !== exp[i]) begin errors++; $display("FAIL rxdata[%0d] got %h want %h", i, d, exp[i]); end
    end
    bus_read(32'h04, d, v);
    checks++; if (d !== 32'h0000_000A) begin errors++; $display("FAIL rx_empty_stat got %h want 0000000a", d); end
  endtask

  task automatic test_rx_simul_overflow();
    logic [31:0] d; logic v;
    for (int i = 1; i <= 15; i++) rx_push(8'(i));
    rx_data = 8'h10; rx_valid = 1'b1; bus.raddr = 32'h0C; bus.ren = 1'b1;
    tick();
    rx_valid = 1'b0; bus.ren = 1'b0;
    checks++; if (bus.rdata !== 32'h8000_0001) begin errors++; $display("FAIL rx_simul_pop got %h want 80000001", bus.rdata); end
    bus_read(32'h04, d, v);
    checks++; if (d !== 32'h000F_0002) begin errors++; $display("FAIL rx_simul_level got %h want 000f0002", d); end
    rx_push(8'h11); rx_push(8'h12);
    bus_read(32'h04, d, v);
    checks++; if (d !== 32'h0010_0026) begin errors++; $display("FAIL rx_ovf_stat got %h want 00100026", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(32'h0C, d, v);
      checks++; if (d !== (32'h8000_0002 + i)) begin
        errors++; $display("FAIL rx_order[%0d] got %h want %h", i, d, 32'h8000_0002 + i); end
    end
    bus_write(32'h04, 32'h20, 4'h1);
    bus_read(32'h04, d, v);
    checks++; if (d !== 32'h0000_000A) begin errors++; $display("FAIL rx_ovf_w1c got %h want 0000000a", d); end
  endtask

  task automatic test_irq_threshold();
    logic [31:0] d; logic v;
    bus_write(32'h10, 32'h0400, 4'h3);
    bus_write(32'h08, 32'h23, 4'h1);
    rx_push(8'hA1); rx_push(8'hA2); rx_push(8'hA3);
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_below got %b want 0", irq); end
    rx_push(8'hA4);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b want 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_thresh got %b want 1", irq); end
    bus_read(32'h0C, d, v);
    checks++; if (d !== 32'h8000_00A1) begin errors++; $display("FAIL irq_pop got %h want 800000a1", d); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got %b want 0", irq); end
    for (int i = 0; i < 3; i++) bus_read(32'h0C, d, v);
    bus_write(32'h08, 32'h03, 4'h1);
    bus_write(32'h10, 32'h0100, 4'h3);
  endtask

  task automatic test_flush_and_reset();
    logic [31:0] d; logic v;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(32'h00, 32'h61 + i, 4'h1);
    bus_read(32'h04, d, v);
    checks++; if (d !== 32'h0000_0548) begin errors++; $display("FAIL flush_pre got %h want 00000548", d); end
    bus_write(32'h08, 32'h07, 4'h1);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got txv=%b want 0", tx_valid); end
    bus_write(32'h00, 32'h99, 4'h1);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h99) begin
      errors++; $display("FAIL flush_push got %b/%h want 1/99", tx_valid, tx_data); end
    bus_read(32'h04, d, v);
    checks++; if (d !== 32'h0000_0148) begin errors++; $display("FAIL flush_level got %h want 00000148", d); end
    bus_read(32'h08, d, v);
    checks++; if (d !== 32'h03) begin errors++; $display("FAIL flush_selfclr got %h want 03", d); end
    bus_write(32'h08, 32'h02, 4'h1);
    bus_read(32'h04, d, v);
    checks++; if (tx_valid !== 1'b0 || d !== 32'h0000_0108) begin
      errors++; $display("FAIL tx_en_hold got %b/%h want 0/00000108", tx_valid, d); end
    bus_write(32'h08, 32'h13, 4'h1);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h99) begin
      errors++; $display("FAIL tx_en_resume got %b/%h want 1/99", tx_valid, tx_data); end
    bus_write(32'h10, 32'h0104, 4'h3);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx got %b want 1", irq); end
    bus.raddr = 32'h04; bus.ren = 1'b1; rst = 1'b1;
    tick();
    bus.ren = 1'b0; rst = 1'b0;
    checks++; if (bus.rvalid !== 1'b0 || tx_valid !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL mid_reset got rv=%b txv=%b irq=%b want 0 0 0", bus.rvalid, tx_valid, irq); end
    bus_read(32'h04, d, v);
    checks++; if (d !== 32'h0000_000A) begin errors++; $display("FAIL post_reset_stat got %h want 0000000a", d); end
    bus_read(32'h10, d, v);
    checks++; if (d !== 32'h0100) begin errors++; $display("FAIL post_reset_thresh got %h want 0100", d); end
  endtask

  initial begin
    bus.waddr = '0; bus.wdata = '0; bus.wen = 1'b0; bus.wstrb = '0;
    bus.raddr = '0; bus.ren = 1'b0;
    test_reset();
    test_tx_overflow();
    test_rx_basic();
    test_rx_simul_overflow();
    test_irq_threshold();
    test_flush_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
